sync_fifo_ram: RTL and testbench
================================

// Module: sync_fifo_ram
// PURPOSE
//  Parametrised single-clock FIFO built on an internal DATA_DEPTH x DATA_WIDTH RAM.
//  Adds pointer management, occupancy count, full/empty and almost flags, registered
//  read data with a valid strobe, and sticky overflow/underflow error flags.
//  Sits between a producer and a consumer in one clock domain, e.g. for rate smoothing.
// PARAMETERS
//  DATA_WIDTH  16  word width in bits
//  DATA_DEPTH  8   number of words stored; 2..2**DATA_ADDR, need not be a power of 2
//  DATA_ADDR   3   pointer width; must satisfy 2**DATA_ADDR >= DATA_DEPTH
//  AF_LEVEL    6   almost_full asserted when count >= AF_LEVEL
//  AE_LEVEL    2   almost_empty asserted when count <= AE_LEVEL
// PORTS
//  clk           in   1             single clock, all state updates on posedge
//  clear         in   1             asynchronous reset, active-high
//  we            in   1             write request
//  d_in          in   DATA_WIDTH    write data
//  re            in   1             read request
//  d_out         out  DATA_WIDTH    registered read data
//  rd_valid      out  1             1-cycle strobe: d_out updated this cycle
//  full          out  1             count == DATA_DEPTH
//  empty         out  1             count == 0
//  almost_full   out  1             count >= AF_LEVEL
//  almost_empty  out  1             count <= AE_LEVEL
//  count         out  DATA_ADDR+1   words currently stored, 0..DATA_DEPTH
//  overflow      out  1             sticky: a write was rejected because FIFO full
//  underflow     out  1             sticky: a read was rejected because FIFO empty
//  err_clr       in   1             synchronous clear of overflow/underflow
// BEHAVIOUR
//  Reset (clear=1, async): wr_ptr=rd_ptr=0, count=0, d_out=0, rd_valid=0,
//   overflow=underflow=0, empty=1, almost_empty=1, full=0, almost_full=0.
//   RAM contents are not cleared.
//  Accept rules, evaluated on pre-edge flags:
//   wr_acc = we & ~full; rd_acc = re & ~empty.
//  wr_acc: ram[wr_ptr] <= d_in; wr_ptr advances.
//  rd_acc: d_out <= ram[rd_ptr]; rd_ptr advances; rd_valid=1 the next cycle, else 0.
//   Latency is 1 clk from accepted re to d_out/rd_valid.
//   d_out holds its last value when no read is accepted.
//  Pointer wrap: ptr == DATA_DEPTH-1 -> 0, explicit compare, not modulo 2**DATA_ADDR.
//  count: +1 on wr_acc only; -1 on rd_acc only; unchanged when both or neither occur.
//   Flags are combinational decodes of registered count.
//  Simultaneous we & re:
//   - not empty and not full: both accepted, count unchanged.
//   - empty: write accepted, read rejected (underflow set); no same-cycle bypass.
//   - full: read accepted, write rejected (overflow set); data is not lost from the RAM.
//  overflow <= 1 on we & full; underflow <= 1 on re & empty.
//   Both clear only by clear or err_clr.
//   If err_clr and a new error occur in the same cycle, the new error wins (flag stays 1).
//  Rejected accesses do not change RAM, pointers, count or d_out.
//  clear asserted mid-operation aborts any access in that cycle.
//   First access after deassertion writes/reads address 0.
// TESTING
//  1. Reset: clear pulse -> empty=1, full=0, count=0, d_out=0, overflow=underflow=0.
//  2. Fill/drain: write 8 words 16'h1001..1008 -> full=1, count=8, almost_full from count 6.
//     Then read 8 -> d_out=1001..1008 in order, each 1 clk after re, rd_valid per word;
//     empty=1 at the end.
//  3. Wrap: write 5, read 5, write 6 (16'hA0..A5), read 6 -> data in order across
//     ptr 7->0; count never exceeds 6.
//  4. Full+we+re: at count=8 assert we(d_in=16'hBEEF) & re -> oldest word read,
//     count=7, overflow=1, 16'hBEEF never appears on d_out.
//  5. Empty+we+re: at count=0 assert we(16'h5555) & re -> count=1, underflow=1,
//     rd_valid=0; next read returns 16'h5555. Then err_clr -> flags 0.
//  6. Async reset mid-stream: at count=4, assert clear between edges -> outputs at reset
//     values immediately; a subsequent write+read returns the new word.

Source files
------------

// File: rtl/sync_fifo_ram_if.sv
// Handshake and status bundle between a producer/consumer pair and sync_fifo_ram.
// The FIFO takes the slave view; the client side takes the master view.
interface sync_fifo_ram_if #(
    parameter int DATA_WIDTH = 16,
    parameter int DATA_ADDR  = 3
);
    logic                  we;
    logic [DATA_WIDTH-1:0] d_in;
    logic                  re;
    logic                  err_clr;
    logic [DATA_WIDTH-1:0] d_out;
    logic                  rd_valid;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [DATA_ADDR:0]    count;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output we, d_in, re, err_clr,
        input  d_out, rd_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  we, d_in, re, err_clr,
        output d_out, rd_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_ram.sv
// Single-clock FIFO on an internal DATA_DEPTH x DATA_WIDTH RAM with occupancy count,
// registered status flags, 1-cycle registered read data and sticky error flags.
module sync_fifo_ram #(
    parameter int DATA_WIDTH = 16,
    parameter int DATA_DEPTH = 8,
    parameter int DATA_ADDR  = 3,
    parameter int AF_LEVEL   = 6,
    parameter int AE_LEVEL   = 2
) (
    input  logic            clk,
    input  logic            clear,
    sync_fifo_ram_if.slave  bus
);

    localparam int CNT_W = DATA_ADDR + 1;

    localparam logic [DATA_ADDR-1:0] PTR_ZERO = {DATA_ADDR{1'b0}};
    localparam logic [DATA_ADDR-1:0] PTR_ONE  = DATA_ADDR'(1);
    localparam logic [DATA_ADDR-1:0] PTR_LAST = DATA_ADDR'(DATA_DEPTH - 1);
    localparam logic [CNT_W-1:0]     CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]     CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]     CNT_FULL = CNT_W'(DATA_DEPTH);
    localparam logic [CNT_W-1:0]     CNT_AF   = CNT_W'(AF_LEVEL);
    localparam logic [CNT_W-1:0]     CNT_AE   = CNT_W'(AE_LEVEL);

    // Explicit wrap so non-power-of-two depths never address past the last word.
    function automatic logic [DATA_ADDR-1:0] ptr_inc(input logic [DATA_ADDR-1:0] ptr);
        logic [DATA_ADDR-1:0] nxt;
        if (ptr == PTR_LAST) begin
            nxt = PTR_ZERO;
        end else begin
            nxt = ptr + PTR_ONE;
        end
        return nxt;
    endfunction

    // Status decode of an occupancy value: {full, empty, almost_full, almost_empty}.
    function automatic logic [3:0] decode_flags(input logic [CNT_W-1:0] cnt);
        logic [3:0] f;
        f[3] = (cnt == CNT_FULL);
        f[2] = (cnt == CNT_ZERO);
        f[1] = (cnt >= CNT_AF);
        f[0] = (cnt <= CNT_AE);
        return f;
    endfunction

    logic [DATA_WIDTH-1:0] ram_r [0:DATA_DEPTH-1];

    logic [DATA_ADDR-1:0]  wr_ptr_r;
    logic [DATA_ADDR-1:0]  rd_ptr_r;
    logic [CNT_W-1:0]      count_r;
    logic [DATA_WIDTH-1:0] d_out_r;
    logic                  rd_valid_r;
    logic                  overflow_r;
    logic                  underflow_r;
    logic                  full_r;
    logic                  empty_r;
    logic                  almost_full_r;
    logic                  almost_empty_r;

    logic                  wr_acc_s;
    logic                  rd_acc_s;
    logic [DATA_ADDR-1:0]  wr_ptr_next_s;
    logic [DATA_ADDR-1:0]  rd_ptr_next_s;
    logic [CNT_W-1:0]      count_next_s;
    logic                  overflow_next_s;
    logic                  underflow_next_s;
    logic [3:0]            flags_next_s;

    // Acceptance uses the flags as they stood before the edge.
    assign wr_acc_s = bus.we & ~full_r;
    assign rd_acc_s = bus.re & ~empty_r;

    // Next-state for pointers, occupancy, derived flags and sticky errors.
    always_comb begin
        wr_ptr_next_s    = wr_ptr_r;
        rd_ptr_next_s    = rd_ptr_r;
        count_next_s     = count_r;
        overflow_next_s  = overflow_r;
        underflow_next_s = underflow_r;
        flags_next_s     = 4'b0000;

        if (wr_acc_s) begin
            wr_ptr_next_s = ptr_inc(wr_ptr_r);
        end else begin
            wr_ptr_next_s = wr_ptr_r;
        end

        if (rd_acc_s) begin
            rd_ptr_next_s = ptr_inc(rd_ptr_r);
        end else begin
            rd_ptr_next_s = rd_ptr_r;
        end

        case ({wr_acc_s, rd_acc_s})
            2'b10:   count_next_s = count_r + CNT_ONE;
            2'b01:   count_next_s = count_r - CNT_ONE;
            default: count_next_s = count_r;
        endcase

        // A fresh error in the same cycle as err_clr keeps the flag set.
        overflow_next_s  = (bus.we & full_r)  | (overflow_r  & ~bus.err_clr);
        underflow_next_s = (bus.re & empty_r) | (underflow_r & ~bus.err_clr);

        flags_next_s = decode_flags(count_next_s);
    end

    // Storage array; deliberately not reset, and an edge seen while clear is high stores nothing.
    always_ff @(posedge clk) begin
        if (wr_acc_s && !clear) begin
            ram_r[wr_ptr_r] <= bus.d_in;
        end
    end

    // Control and output registers.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            wr_ptr_r       <= PTR_ZERO;
            rd_ptr_r       <= PTR_ZERO;
            count_r        <= CNT_ZERO;
            d_out_r        <= {DATA_WIDTH{1'b0}};
            rd_valid_r     <= 1'b0;
            overflow_r     <= 1'b0;
            underflow_r    <= 1'b0;
            full_r         <= decode_flags(CNT_ZERO) >> 3;
            empty_r        <= decode_flags(CNT_ZERO) >> 2;
            almost_full_r  <= decode_flags(CNT_ZERO) >> 1;
            almost_empty_r <= decode_flags(CNT_ZERO) >> 0;
        end else begin
            wr_ptr_r       <= wr_ptr_next_s;
            rd_ptr_r       <= rd_ptr_next_s;
            count_r        <= count_next_s;
            rd_valid_r     <= rd_acc_s;
            overflow_r     <= overflow_next_s;
            underflow_r    <= underflow_next_s;
            full_r         <= flags_next_s[3];
            empty_r        <= flags_next_s[2];
            almost_full_r  <= flags_next_s[1];
            almost_empty_r <= flags_next_s[0];
            if (rd_acc_s) begin
                d_out_r <= ram_r[rd_ptr_r];
            end else begin
                d_out_r <= d_out_r;
            end
        end
    end

    assign bus.d_out        = d_out_r;
    assign bus.rd_valid     = rd_valid_r;
    assign bus.full         = full_r;
    assign bus.empty        = empty_r;
    assign bus.almost_full  = almost_full_r;
    assign bus.almost_empty = almost_empty_r;
    assign bus.count        = count_r;
    assign bus.overflow     = overflow_r;
    assign bus.underflow    = underflow_r;

endmodule

// File: tb/tb_sync_fifo_ram.sv
// Directed bench for sync_fifo_ram: reset, fill/drain, pointer wrap, full and empty
// collisions, sticky error clearing and asynchronous reset mid-stream.
module tb_sync_fifo_ram;

    logic clk;
    logic clear;
    int   n_checks;
    int   n_fails;

    sync_fifo_ram_if #(.DATA_WIDTH(16), .DATA_ADDR(3)) bus ();

    sync_fifo_ram #(
        .DATA_WIDTH(16),
        .DATA_DEPTH(8),
        .DATA_ADDR (3),
        .AF_LEVEL  (6),
        .AE_LEVEL  (2)
    ) dut (
        .clk  (clk),
        .clear(clear),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.we      = 1'b0;
        bus.re      = 1'b0;
        bus.err_clr = 1'b0;
        bus.d_in    = 16'h0000;
    endtask

    task automatic push(input logic [15:0] v);
        bus.we   = 1'b1;
        bus.d_in = v;
        tick();
        idle();
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        idle();
        clear = 1'b1;
        #12;
        clear = 1'b0;
        #2;

        // Reset state
        check_eq("rst_empty", 32'(bus.empty), 32'd1);
        check_eq("rst_full", 32'(bus.full), 32'd0);
        check_eq("rst_count", 32'(bus.count), 32'd0);
        check_eq("rst_dout", 32'(bus.d_out), 32'h0);
        check_eq("rst_ovf", 32'(bus.overflow), 32'd0);
        check_eq("rst_unf", 32'(bus.underflow), 32'd0);
        check_eq("rst_ae", 32'(bus.almost_empty), 32'd1);
        check_eq("rst_af", 32'(bus.almost_full), 32'd0);

        // Fill with 1001..1008
        for (int i = 0; i < 8; i++) begin
            push(16'h1001 + 16'(i));
            check_eq("fill_count", 32'(bus.count), 32'(i + 1));
            check_eq("fill_af", 32'(bus.almost_full), (i + 1 >= 6) ? 32'd1 : 32'd0);
            check_eq("fill_ae", 32'(bus.almost_empty), (i + 1 <= 2) ? 32'd1 : 32'd0);
            check_eq("fill_full", 32'(bus.full), (i == 7) ? 32'd1 : 32'd0);
            check_eq("fill_empty", 32'(bus.empty), 32'd0);
        end

        // Drain in order, one word per cycle
        bus.re = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check_eq("drain_dout", 32'(bus.d_out), 32'(16'h1001 + 16'(i)));
            check_eq("drain_valid", 32'(bus.rd_valid), 32'd1);
            check_eq("drain_count", 32'(bus.count), 32'(7 - i));
        end
        idle();
        tick();
        check_eq("drain_valid_off", 32'(bus.rd_valid), 32'd0);
        check_eq("drain_empty", 32'(bus.empty), 32'd1);
        check_eq("drain_hold", 32'(bus.d_out), 32'h1008);
        check_eq("drain_unf", 32'(bus.underflow), 32'd0);

        // Wrap: write 5, read 5, then 6 words that cross address 7 -> 0
        for (int i = 0; i < 5; i++) push(16'h0050 + 16'(i));
        bus.re = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("wrap_pre_dout", 32'(bus.d_out), 32'(16'h0050 + 16'(i)));
        end
        idle();
        for (int i = 0; i < 6; i++) begin
            push(16'h00A0 + 16'(i));
            check_eq("wrap_count", 32'(bus.count), 32'(i + 1));
        end
        bus.re = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check_eq("wrap_dout", 32'(bus.d_out), 32'(16'h00A0 + 16'(i)));
        end
        idle();
        tick();
        check_eq("wrap_empty", 32'(bus.empty), 32'd1);

        // Full with simultaneous write and read
        for (int i = 0; i < 8; i++) push(16'h2000 + 16'(i));
        check_eq("coll_full_pre", 32'(bus.full), 32'd1);
        bus.we   = 1'b1;
        bus.d_in = 16'hBEEF;
        bus.re   = 1'b1;
        tick();
        idle();
        check_eq("coll_full_dout", 32'(bus.d_out), 32'h2000);
        check_eq("coll_full_count", 32'(bus.count), 32'd7);
        check_eq("coll_full_ovf", 32'(bus.overflow), 32'd1);
        check_eq("coll_full_flag", 32'(bus.full), 32'd0);
        bus.re = 1'b1;
        for (int i = 1; i < 8; i++) begin
            tick();
            check_eq("coll_full_drain", 32'(bus.d_out), 32'(16'h2000 + 16'(i)));
        end
        idle();
        tick();
        check_eq("coll_full_empty", 32'(bus.count), 32'd0);
        check_eq("coll_ovf_sticky", 32'(bus.overflow), 32'd1);

        // Empty with simultaneous write and read: no bypass
        bus.we   = 1'b1;
        bus.d_in = 16'h5555;
        bus.re   = 1'b1;
        tick();
        idle();
        check_eq("coll_empty_count", 32'(bus.count), 32'd1);
        check_eq("coll_empty_unf", 32'(bus.underflow), 32'd1);
        check_eq("coll_empty_valid", 32'(bus.rd_valid), 32'd0);
        check_eq("coll_empty_dout", 32'(bus.d_out), 32'h2007);
        bus.re = 1'b1;
        tick();
        idle();
        check_eq("coll_empty_read", 32'(bus.d_out), 32'h5555);
        check_eq("coll_empty_rv", 32'(bus.rd_valid), 32'd1);

        // err_clr clears both; a new error in the same cycle wins
        bus.err_clr = 1'b1;
        tick();
        idle();
        check_eq("errclr_ovf", 32'(bus.overflow), 32'd0);
        check_eq("errclr_unf", 32'(bus.underflow), 32'd0);
        bus.err_clr = 1'b1;
        bus.re      = 1'b1;
        tick();
        idle();
        check_eq("errclr_race_unf", 32'(bus.underflow), 32'd1);
        bus.err_clr = 1'b1;
        tick();
        idle();
        check_eq("errclr_again", 32'(bus.underflow), 32'd0);

        // Asynchronous clear between edges at count 4
        for (int i = 0; i < 4; i++) push(16'h3000 + 16'(i));
        check_eq("async_pre_count", 32'(bus.count), 32'd4);
        #2;
        clear = 1'b1;
        #1;
        check_eq("async_count", 32'(bus.count), 32'd0);
        check_eq("async_empty", 32'(bus.empty), 32'd1);
        check_eq("async_dout", 32'(bus.d_out), 32'h0);
        check_eq("async_ae", 32'(bus.almost_empty), 32'd1);
        clear = 1'b0;
        push(16'h7777);
        bus.re = 1'b1;
        tick();
        idle();
        check_eq("async_after_dout", 32'(bus.d_out), 32'h7777);
        check_eq("async_after_rv", 32'(bus.rd_valid), 32'd1);
        tick();
        check_eq("async_after_empty", 32'(bus.empty), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
